stepdir_gen2: RTL
=================

Name: stepdir_gen2

Overview:
Second-generation step/direction pulse generator for one motor axis, fed by a move queue of the team's standard fifo.
- Executes constant-interval and linear-accel moves, plus dwells.
- Adds programmable step pulse width and dir-to-step setup time.
- Adds double-edge mode, abort, position preload and sticky error reporting.
- Sits between the command decoder (queue writer) and the driver pins.

Parameters:
MOVE_TYPE_BITS, 3, move type field width
STEP_INTERVAL_BITS, 22, interval width (clock cycles)
STEP_COUNT_BITS, 26, step/dwell count width
STEP_ADD_BITS, 20, signed per-step interval delta width (<= STEP_INTERVAL_BITS)
MOVE_COUNT, 512, queue depth (power of 2)
PULSE_BITS, 8, width of pulse_width / dir_setup
POS_BITS, 32, position counter width

Ports:
clk  in  1  clock
reset  in  1  sync active-high reset
queue_wr_data  in  QW  move word {type, dir, interval, count, add}, MSB first; QW = MOVE_TYPE_BITS+1+STEP_INTERVAL_BITS+STEP_COUNT_BITS+STEP_ADD_BITS (72 default)
queue_wr_en  in  1  push; ignored when full
queue_full  out  1  fifo full
queue_empty  out  1  fifo empty
start  in  1  begin executing queue
abort  in  1  stop immediately and flush queue
dedge  in  1  1 = toggle step per step event
pulse_width  in  PULSE_BITS  step high time in cycles; 0 is treated as 1
dir_setup  in  PULSE_BITS  minimum cycles from dir change to next step edge
pos_load  in  1  load position
pos_load_val  in  POS_BITS  value for pos_load
step  out  1  step pin
dir  out  1  dir pin
running  out  1  executing moves
error  out  2  sticky: [0] unknown move type, [1] interval saturated
position  out  POS_BITS  signed step position, wraps

Behaviour:
- Reset values: step, dir, running, error, position all 0. Reset also clears the fifo and returns the FSM to IDLE.
- Reset has priority over everything, including mid-move and mid-pulse.
- Move types:
  - 0 = step move.
  - 1 = dwell: count*(interval+1) cycles with no steps, dir untouched.
  - Other types: entry discarded, error[0] set, execution continues with the next entry.
- FSM states: IDLE, LOAD, DIRSET, WAIT, NEXT.
  - IDLE: if start && !empty, go to LOAD.
  - LOAD: 1 cycle. Pops the head with a 1-cycle rd_en and latches the fields.
    - count==0: go to NEXT.
    - Step move with q_dir != dir: dir changes only while step is low (LOAD holds while step is high). Load dir_setup, go to DIRSET; skip straight to WAIT if dir_setup==0.
    - Otherwise go to WAIT with curr = interval.
  - DIRSET: counts down to 0, then goes to WAIT.
  - WAIT: curr decrements each cycle. When curr==0 is sampled:
    - Step move, normal mode: step event requires step to have been low for at least 1 cycle; otherwise the event is deferred cycle by cycle.
    - count--; interval <= sat(interval + sign-extended add); curr <= the new interval.
    - When count reaches 0, go to NEXT.
  - NEXT: if !empty go to LOAD, else go to IDLE. running falls in the same cycle IDLE is entered.
- running is registered: it rises the cycle after start is accepted and is 1 in every non-IDLE state.
- Timing: start sampled in cycle T with an equal-dir move of interval I gives LOAD at T+1, WAIT at T+2, and step rising in T+3+I.
  - Gap between step event k and k+1 = interval_(k+1) + 1 cycles, where interval_(k+1) = I + (k+1)*add, saturated.
- Step pulse, normal mode: step high for max(pulse_width,1) cycles, counted by an independent pulse counter that runs concurrently with WAIT.
- dedge=1: step toggles on each step event and pulse_width is ignored. The step level persists across moves and idle.
- Saturation: interval + add clamps to 0 (negative overflow) or all-ones (positive overflow) and sets error[1].
- position changes on each step event: +1 if dir=1, else -1, modulo 2^POS_BITS.
  - pos_load sets position to pos_load_val.
  - If a step event coincides with pos_load, position = pos_load_val ±1.
- abort, in any state:
  - Next cycle: FSM in IDLE, count cleared, fifo cleared, running = 0.
  - An active pulse completes its programmed width.
  - abort outranks a simultaneous start.
- start while running: ignored. Empty queue with start: stays IDLE.
- Write while full: dropped, no error. Simultaneous push and pop when full: pop succeeds, push dropped.
- error bits are cleared only by reset.

Test Plan:
1. Reset, push {type0, dir1, I=4, count=3, add=0}, pulse_width=2, start at T -> step rises T+7, T+12, T+17, each high 2 cycles; position=3; running falls after the 3rd step; dir=1.
2. Move {dir1, I=10, count=4, add=-2}, then {dir0, I=5, count=1}, dir_setup=6 -> gaps 9, 7, 5 cycles; dir falls only with step low; the next step is no sooner than 6 cycles after dir falls; position ends at 3.
3. Move {I=2, add=-3, count=3} -> interval clamps to 0, error[1]=1, steps every cycle gap 1 (pulse deferral stretches to 2 with pulse_width=1); then entry type=5 -> discarded, error[0]=1.
4. dedge=1, {dir0, I=3, count=4} -> step toggles 4 times, 4-cycle spacing, ending at the starting level; position=-4.
5. Abort during 2nd step of a 100-step move while pulse is high -> pulse finishes its width, running=0 and queue_empty=1 the next cycle, no further steps; pos_load of 1000 in the same cycle as a step event with dir=1 -> position=1001.
6. Push MOVE_COUNT+1 words -> queue_full=1, last word dropped; reset mid-move -> all outputs 0 the next cycle.

Source files
------------

// File: rtl/stepdir_gen2.sv
// stepdir_gen2 -- step/direction pulse generator for one motor axis.
//
// Moves are pushed into an internal queue and executed in order once started:
// constant-interval or linearly accelerating step moves, and dwells. The step
// pulse width and the dir-to-step setup time are programmable. Double-edge
// mode, abort, position preload and sticky error flags are also provided.
//
// Queue handshake: i_queue_wr_en is a push qualifier with o_queue_full as the
// ready. A word is accepted on a rising clk edge where i_queue_wr_en=1 and
// o_queue_full=0. A push attempted while full is dropped silently, even when
// the same cycle pops an entry.
//
// Ports:
//   clk, reset          clock; synchronous active-high reset
//   i_queue_wr_data     move word {type, dir, interval, count, add}, MSB first
//   i_queue_wr_en       push request
//   o_queue_full/empty  queue status
//   i_start             begin executing the queue (ignored while running)
//   i_abort             stop now and flush the queue; any active pulse completes
//   i_dedge             1 = step toggles once per step event
//   i_pulse_width       step high time in cycles (0 behaves as 1)
//   i_dir_setup         minimum cycles from a dir change to the next step edge
//   i_pos_load          load o_position from i_pos_load_val
//   o_step, o_dir       driver pins
//   o_running           executing moves (registered)
//   o_error             sticky: [0] unknown move type, [1] interval saturated
//   o_position          signed step position; wraps
//   o_dbg_state         FSM state (IDLE=0 LOAD=1 DIRSET=2 WAIT=3 NEXT=4)
module stepdir_gen2 #(
  parameter int MOVE_TYPE_BITS     = 3,
  parameter int STEP_INTERVAL_BITS = 22,
  parameter int STEP_COUNT_BITS    = 26,
  parameter int STEP_ADD_BITS      = 20,
  parameter int MOVE_COUNT         = 512,
  parameter int PULSE_BITS         = 8,
  parameter int POS_BITS           = 32,
  localparam int QW = MOVE_TYPE_BITS + 1 + STEP_INTERVAL_BITS + STEP_COUNT_BITS + STEP_ADD_BITS
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [QW-1:0]         i_queue_wr_data,
  input  logic                  i_queue_wr_en,
  output logic                  o_queue_full,
  output logic                  o_queue_empty,
  input  logic                  i_start,
  input  logic                  i_abort,
  input  logic                  i_dedge,
  input  logic [PULSE_BITS-1:0] i_pulse_width,
  input  logic [PULSE_BITS-1:0] i_dir_setup,
  input  logic                  i_pos_load,
  input  logic [POS_BITS-1:0]   i_pos_load_val,
  output logic                  o_step,
  output logic                  o_dir,
  output logic                  o_running,
  output logic [1:0]            o_error,
  output logic [POS_BITS-1:0]   o_position,
  output logic [2:0]            o_dbg_state
);

  localparam int AW       = $clog2(MOVE_COUNT);
  localparam int CNT_LSB  = STEP_ADD_BITS;
  localparam int INT_LSB  = CNT_LSB + STEP_COUNT_BITS;
  localparam int DIR_POS  = INT_LSB + STEP_INTERVAL_BITS;
  localparam int TYPE_LSB = DIR_POS + 1;
  localparam int SW       = STEP_INTERVAL_BITS + 2;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_DIRSET = 3'd2,
    S_WAIT   = 3'd3,
    S_NEXT   = 3'd4
  } state_t;

  // ---------------------------------------------------------------- queue
  logic [QW-1:0] r_mem [MOVE_COUNT];
  logic [AW:0]   r_wr_ptr, r_rd_ptr;
  logic          w_full, w_empty, w_push, w_pop;
  logic [QW-1:0] w_head;

  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_push  = i_queue_wr_en && !w_full;
  assign w_head  = r_mem[r_rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= i_queue_wr_data;
  end

  always_ff @(posedge clk) begin
    if (reset || i_abort) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  // Head-of-queue fields
  logic [MOVE_TYPE_BITS-1:0]     w_h_type;
  logic                          w_h_dir;
  logic [STEP_INTERVAL_BITS-1:0] w_h_interval;
  logic [STEP_COUNT_BITS-1:0]    w_h_count;
  logic [STEP_ADD_BITS-1:0]      w_h_add;
  logic                          w_h_is_step, w_h_known;

  assign w_h_type     = w_head[TYPE_LSB +: MOVE_TYPE_BITS];
  assign w_h_dir      = w_head[DIR_POS];
  assign w_h_interval = w_head[INT_LSB +: STEP_INTERVAL_BITS];
  assign w_h_count    = w_head[CNT_LSB +: STEP_COUNT_BITS];
  assign w_h_add      = w_head[0 +: STEP_ADD_BITS];
  assign w_h_is_step  = (w_h_type == MOVE_TYPE_BITS'(0));
  assign w_h_known    = w_h_is_step || (w_h_type == MOVE_TYPE_BITS'(1));

  // ------------------------------------------------------------ registers
  state_t                        r_state, w_state_next;
  logic                          r_dwell;
  logic [STEP_INTERVAL_BITS-1:0] r_interval, r_curr;
  logic [STEP_COUNT_BITS-1:0]    r_count;
  logic [STEP_ADD_BITS-1:0]      r_add;
  logic [PULSE_BITS-1:0]         r_dset, r_pcnt;
  logic                          r_step, r_dir, r_running;
  logic [1:0]                    r_error;
  logic [POS_BITS-1:0]           r_position;

  // Next interval: unsigned interval plus sign-extended add, clamped.
  logic signed [SW-1:0]          w_sum;
  logic [STEP_INTERVAL_BITS-1:0] w_int_next;
  logic                          w_sat;

  assign w_sum = $signed({2'b00, r_interval})
               + $signed({{(SW-STEP_ADD_BITS){r_add[STEP_ADD_BITS-1]}}, r_add});

  always_comb begin
    w_int_next = r_interval;
    w_sat      = 1'b0;
    if (!r_dwell) begin
      if (w_sum[SW-1]) begin
        w_int_next = '0;
        w_sat      = 1'b1;
      end else if (w_sum[SW-2]) begin
        w_int_next = '1;
        w_sat      = 1'b1;
      end else begin
        w_int_next = w_sum[STEP_INTERVAL_BITS-1:0];
      end
    end
  end

  // ------------------------------------------------------------------ FSM
  logic w_latch, w_set_dir, w_dset_load, w_curr_from_head, w_curr_from_int;
  logic w_tick, w_event, w_bad_type, w_dir_hold;

  // A dir change waits in LOAD while a normal-mode pulse is still high. In
  // double-edge mode the step level is a steady state, so no wait applies.
  assign w_dir_hold = w_h_is_step && (w_h_count != '0) && (w_h_dir != r_dir)
                      && r_step && !i_dedge;

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next     = r_state;
    w_pop            = 1'b0;
    w_latch          = 1'b0;
    w_set_dir        = 1'b0;
    w_dset_load      = 1'b0;
    w_curr_from_head = 1'b0;
    w_curr_from_int  = 1'b0;
    w_tick           = 1'b0;
    w_event          = 1'b0;
    w_bad_type       = 1'b0;
    case (r_state)
      S_IDLE: if (i_start && !w_empty) w_state_next = S_LOAD;
      S_LOAD: begin
        if (!w_dir_hold) begin
          w_pop   = 1'b1;
          w_latch = 1'b1;
          if (!w_h_known) begin
            w_bad_type   = 1'b1;
            w_state_next = S_NEXT;
          end else if (w_h_count == '0) begin
            w_state_next = S_NEXT;
          end else if (w_h_is_step && (w_h_dir != r_dir)) begin
            w_set_dir = 1'b1;
            if (i_dir_setup == '0) begin
              w_curr_from_head = 1'b1;
              w_state_next     = S_WAIT;
            end else begin
              w_dset_load  = 1'b1;
              w_state_next = S_DIRSET;
            end
          end else begin
            w_curr_from_head = 1'b1;
            w_state_next     = S_WAIT;
          end
        end
      end
      S_DIRSET: begin
        if (r_dset == '0) begin
          w_curr_from_int = 1'b1;
          w_state_next    = S_WAIT;
        end
      end
      S_WAIT: begin
        if (r_curr == '0) begin
          if (r_dwell) begin
            w_tick = 1'b1;
          end else if (i_dedge || !r_step) begin
            // Normal mode defers the event until step has been low a cycle.
            w_tick  = 1'b1;
            w_event = 1'b1;
          end
          if (w_tick && (r_count == STEP_COUNT_BITS'(1))) w_state_next = S_NEXT;
        end
      end
      S_NEXT:  w_state_next = w_empty ? S_IDLE : S_LOAD;
      default: w_state_next = S_IDLE;
    endcase
    if (i_abort) begin
      w_state_next     = S_IDLE;
      w_pop            = 1'b0;
      w_latch          = 1'b0;
      w_set_dir        = 1'b0;
      w_dset_load      = 1'b0;
      w_curr_from_head = 1'b0;
      w_curr_from_int  = 1'b0;
      w_tick           = 1'b0;
      w_event          = 1'b0;
      w_bad_type       = 1'b0;
    end
  end

  // ------------------------------------------------------------- datapath
  logic [POS_BITS-1:0] w_pos_base;
  assign w_pos_base = i_pos_load ? i_pos_load_val : r_position;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_dwell    <= 1'b0;
      r_interval <= '0;
      r_curr     <= '0;
      r_count    <= '0;
      r_add      <= '0;
      r_dset     <= '0;
      r_pcnt     <= '0;
      r_step     <= 1'b0;
      r_dir      <= 1'b0;
      r_running  <= 1'b0;
      r_error    <= 2'b00;
      r_position <= '0;
    end else begin
      r_running <= (w_state_next != S_IDLE);

      if (w_latch) begin
        r_dwell    <= (w_h_type == MOVE_TYPE_BITS'(1));
        r_interval <= w_h_interval;
        r_count    <= w_h_count;
        r_add      <= w_h_add;
      end
      if (w_set_dir) r_dir <= w_h_dir;

      if (w_dset_load)                               r_dset <= i_dir_setup;
      else if (r_state == S_DIRSET && r_dset != '0) r_dset <= r_dset - 1'b1;

      if (w_curr_from_head)                        r_curr <= w_h_interval;
      else if (w_curr_from_int)                    r_curr <= r_interval;
      else if (w_tick)                             r_curr <= w_int_next;
      else if (r_state == S_WAIT && r_curr != '0) r_curr <= r_curr - 1'b1;

      if (w_tick) begin
        r_count    <= r_count - 1'b1;
        r_interval <= w_int_next;
      end
      if (i_abort) r_count <= '0;

      if (w_bad_type)       r_error[0] <= 1'b1;
      if (w_tick && w_sat)  r_error[1] <= 1'b1;

      // Pulse counter runs independently of the FSM so abort cannot cut it.
      if (w_event) begin
        if (i_dedge) begin
          r_step <= ~r_step;
        end else begin
          r_step <= 1'b1;
          r_pcnt <= (i_pulse_width == '0) ? '0 : i_pulse_width - 1'b1;
        end
      end else if (!i_dedge && r_step) begin
        if (r_pcnt == '0) r_step <= 1'b0;
        else              r_pcnt <= r_pcnt - 1'b1;
      end

      if (w_event)
        r_position <= r_dir ? w_pos_base + POS_BITS'(1) : w_pos_base - POS_BITS'(1);
      else
        r_position <= w_pos_base;
    end
  end

  assign o_queue_full  = w_full;
  assign o_queue_empty = w_empty;
  assign o_step        = r_step;
  assign o_dir         = r_dir;
  assign o_running     = r_running;
  assign o_error       = r_error;
  assign o_position    = r_position;
  assign o_dbg_state   = r_state;

endmodule
